// File: rtl/id_ex_register.sv
// Decode-to-execute pipeline register with stall hold, flush bubble insertion,
// and a saturating counter of bubbles delivered to the execute stage.
module id_ex_register #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic                  regwrite_i,
    input  logic                  memtoreg_i,
    input  logic                  memread_i,
    input  logic                  memwrite_i,
    input  logic                  alusrc_i,
    input  logic                  regdst_i,
    input  logic [1:0]            aluop_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  valid_o,
    output logic                  regwrite_o,
    output logic                  memtoreg_o,
    output logic                  memread_o,
    output logic                  memwrite_o,
    output logic                  alusrc_o,
    output logic                  regdst_o,
    output logic [1:0]            aluop_o,
    output logic [DATA_W-1:0]     rs_data_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] rs_addr_o,
    output logic [REG_ADDR_W-1:0] rt_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    logic                  valid_reg,    valid_next;
    logic                  regwrite_reg, regwrite_next;
    logic                  memtoreg_reg, memtoreg_next;
    logic                  memread_reg,  memread_next;
    logic                  memwrite_reg, memwrite_next;
    logic                  alusrc_reg,   alusrc_next;
    logic                  regdst_reg,   regdst_next;
    logic [1:0]            aluop_reg,    aluop_next;
    logic [DATA_W-1:0]     rs_data_reg,  rs_data_next;
    logic [DATA_W-1:0]     rt_data_reg,  rt_data_next;
    logic [DATA_W-1:0]     imm_reg,      imm_next;
    logic [REG_ADDR_W-1:0] rs_addr_reg,  rs_addr_next;
    logic [REG_ADDR_W-1:0] rt_addr_reg,  rt_addr_next;
    logic [REG_ADDR_W-1:0] rd_addr_reg,  rd_addr_next;
    logic [CNT_W-1:0]      bubble_cnt_reg, bubble_cnt_next;
    logic                  bubble_latched;

    always_comb begin
        valid_next      = valid_reg;
        regwrite_next   = regwrite_reg;
        memtoreg_next   = memtoreg_reg;
        memread_next    = memread_reg;
        memwrite_next   = memwrite_reg;
        alusrc_next     = alusrc_reg;
        regdst_next     = regdst_reg;
        aluop_next      = aluop_reg;
        rs_data_next    = rs_data_reg;
        rt_data_next    = rt_data_reg;
        imm_next        = imm_reg;
        rs_addr_next    = rs_addr_reg;
        rt_addr_next    = rt_addr_reg;
        rd_addr_next    = rd_addr_reg;
        bubble_latched  = 1'b0;

        if (flush_i) begin
            valid_next     = 1'b0;
            regwrite_next  = 1'b0;
            memtoreg_next  = 1'b0;
            memread_next   = 1'b0;
            memwrite_next  = 1'b0;
            alusrc_next    = 1'b0;
            regdst_next    = 1'b0;
            aluop_next     = '0;
            rs_data_next   = '0;
            rt_data_next   = '0;
            imm_next       = '0;
            rs_addr_next   = '0;
            rt_addr_next   = '0;
            rd_addr_next   = '0;
            bubble_latched = 1'b1;
        end else if (!stall_i) begin
            // An invalid slot keeps its datapath fields but loses every
            // control bit that could alter architectural state.
            valid_next     = valid_i;
            regwrite_next  = regwrite_i & valid_i;
            memtoreg_next  = memtoreg_i & valid_i;
            memread_next   = memread_i  & valid_i;
            memwrite_next  = memwrite_i & valid_i;
            alusrc_next    = alusrc_i;
            regdst_next    = regdst_i;
            aluop_next     = aluop_i;
            rs_data_next   = rs_data_i;
            rt_data_next   = rt_data_i;
            imm_next       = imm_i;
            rs_addr_next   = rs_addr_i;
            rt_addr_next   = rt_addr_i;
            rd_addr_next   = rd_addr_i;
            bubble_latched = ~valid_i;
        end

        bubble_cnt_next = bubble_cnt_reg;
        if (bubble_latched && !(&bubble_cnt_reg))
            bubble_cnt_next = bubble_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_reg      <= 1'b0;
            regwrite_reg   <= 1'b0;
            memtoreg_reg   <= 1'b0;
            memread_reg    <= 1'b0;
            memwrite_reg   <= 1'b0;
            alusrc_reg     <= 1'b0;
            regdst_reg     <= 1'b0;
            aluop_reg      <= '0;
            rs_data_reg    <= '0;
            rt_data_reg    <= '0;
            imm_reg        <= '0;
            rs_addr_reg    <= '0;
            rt_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            valid_reg      <= valid_next;
            regwrite_reg   <= regwrite_next;
            memtoreg_reg   <= memtoreg_next;
            memread_reg    <= memread_next;
            memwrite_reg   <= memwrite_next;
            alusrc_reg     <= alusrc_next;
            regdst_reg     <= regdst_next;
            aluop_reg      <= aluop_next;
            rs_data_reg    <= rs_data_next;
            rt_data_reg    <= rt_data_next;
            imm_reg        <= imm_next;
            rs_addr_reg    <= rs_addr_next;
            rt_addr_reg    <= rt_addr_next;
            rd_addr_reg    <= rd_addr_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign valid_o      = valid_reg;
    assign regwrite_o   = regwrite_reg;
    assign memtoreg_o   = memtoreg_reg;
    assign memread_o    = memread_reg;
    assign memwrite_o   = memwrite_reg;
    assign alusrc_o     = alusrc_reg;
    assign regdst_o     = regdst_reg;
    assign aluop_o      = aluop_reg;
    assign rs_data_o    = rs_data_reg;
    assign rt_data_o    = rt_data_reg;
    assign imm_o        = imm_reg;
    assign rs_addr_o    = rs_addr_reg;
    assign rt_addr_o    = rt_addr_reg;
    assign rd_addr_o    = rd_addr_reg;
    assign bubble_cnt_o = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: a 16-bit-counter instance for function
// and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_id_ex_register;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, valid_i;
    logic        regwrite_i, memtoreg_i, memread_i, memwrite_i, alusrc_i, regdst_i;
    logic [1:0]  aluop_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;

    logic        valid_o, regwrite_o, memtoreg_o, memread_o, memwrite_o, alusrc_o, regdst_o;
    logic [1:0]  aluop_o;
    logic [31:0] rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic [15:0] bubble_cnt_o;

    logic        s_valid_o, s_regwrite_o, s_memtoreg_o, s_memread_o, s_memwrite_o, s_alusrc_o, s_regdst_o;
    logic [1:0]  s_aluop_o;
    logic [31:0] s_rs_data_o, s_rt_data_o, s_imm_o;
    logic [4:0]  s_rs_addr_o, s_rt_addr_o, s_rd_addr_o;
    logic [3:0]  s_bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    id_ex_register dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .memread_i(memread_i),
        .memwrite_i(memwrite_i), .alusrc_i(alusrc_i), .regdst_i(regdst_i), .aluop_i(aluop_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .valid_o(valid_o), .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o), .memread_o(memread_o),
        .memwrite_o(memwrite_o), .alusrc_o(alusrc_o), .regdst_o(regdst_o), .aluop_o(aluop_o),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_register #(.CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .memread_i(memread_i),
        .memwrite_i(memwrite_i), .alusrc_i(alusrc_i), .regdst_i(regdst_i), .aluop_i(aluop_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .valid_o(s_valid_o), .regwrite_o(s_regwrite_o), .memtoreg_o(s_memtoreg_o),
        .memread_o(s_memread_o), .memwrite_o(s_memwrite_o), .alusrc_o(s_alusrc_o),
        .regdst_o(s_regdst_o), .aluop_o(s_aluop_o),
        .rs_data_o(s_rs_data_o), .rt_data_o(s_rt_data_o), .imm_o(s_imm_o),
        .rs_addr_o(s_rs_addr_o), .rt_addr_o(s_rt_addr_o), .rd_addr_o(s_rd_addr_o),
        .bubble_cnt_o(s_bubble_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 0; flush_i = 0; valid_i = 0;
        regwrite_i = 0; memtoreg_i = 0; memread_i = 0; memwrite_i = 0;
        alusrc_i = 0; regdst_i = 0; aluop_i = 2'b00;
        rs_data_i = '0; rt_data_i = '0; imm_i = '0;
        rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0;
    endtask

    task automatic randomize_inputs();
        valid_i = 1'($urandom); regwrite_i = 1'($urandom); memtoreg_i = 1'($urandom);
        memread_i = 1'($urandom); memwrite_i = 1'($urandom); alusrc_i = 1'($urandom);
        regdst_i = 1'($urandom); aluop_i = 2'($urandom);
        rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
        rs_addr_i = 5'($urandom); rt_addr_i = 5'($urandom); rd_addr_i = 5'($urandom);
        stall_i = 1'($urandom); flush_i = 1'($urandom);
    endtask

    logic [31:0] imm_seq [8];

    initial begin
        clear_inputs();
        rst_i = 1'b0;

        // Reset held two edges with random inputs
        randomize_inputs();
        step();
        randomize_inputs();
        step();
        check("rst_valid", valid_o, 0);
        check("rst_regwrite", regwrite_o, 0);
        check("rst_memwrite", memwrite_o, 0);
        check("rst_aluop", aluop_o, 0);
        check("rst_rs_data", rs_data_o, 0);
        check("rst_imm", imm_o, 0);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_cnt", bubble_cnt_o, 0);
        check("rst_cnt_sat", s_bubble_cnt_o, 0);

        // First load after reset, negative immediate passes bit-exact
        clear_inputs();
        rst_i = 1'b1;
        valid_i = 1; regwrite_i = 1; imm_i = 32'hFFFF_8000; rd_addr_i = 5'd5;
        step();
        check("load_regwrite", regwrite_o, 1);
        check("load_imm", imm_o, 64'hFFFF_8000);
        check("load_rd_addr", rd_addr_o, 5);
        check("load_valid", valid_o, 1);
        check("load_cnt", bubble_cnt_o, 0);

        // Stall holds for three edges
        clear_inputs();
        valid_i = 1; rs_data_i = 32'h1234_5678;
        step();
        check("pre_stall_rs", rs_data_o, 64'h1234_5678);
        stall_i = 1; rs_data_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_rs_%0d", i), rs_data_o, 64'h1234_5678);
        end
        stall_i = 0;
        step();
        check("unstall_rs", rs_data_o, 64'hDEAD_BEEF);
        check("unstall_cnt", bubble_cnt_o, 0);

        // Flush overrides stall
        stall_i = 1; flush_i = 1; memwrite_i = 1; valid_i = 1;
        rt_data_i = 32'hCAFE_0001; imm_i = 32'h0000_00FF; rs_addr_i = 5'd3;
        step();
        check("flush_memwrite", memwrite_o, 0);
        check("flush_valid", valid_o, 0);
        check("flush_rs_data", rs_data_o, 0);
        check("flush_rt_data", rt_data_o, 0);
        check("flush_imm", imm_o, 0);
        check("flush_rs_addr", rs_addr_o, 0);
        check("flush_cnt", bubble_cnt_o, 1);

        // Invalid load strips state-changing controls, keeps the rest
        clear_inputs();
        valid_i = 0; regwrite_i = 1; memwrite_i = 1; memread_i = 1; memtoreg_i = 1;
        alusrc_i = 1; aluop_i = 2'b10; rt_addr_i = 5'd7;
        step();
        check("inv_regwrite", regwrite_o, 0);
        check("inv_memwrite", memwrite_o, 0);
        check("inv_memread", memread_o, 0);
        check("inv_memtoreg", memtoreg_o, 0);
        check("inv_valid", valid_o, 0);
        check("inv_alusrc", alusrc_o, 1);
        check("inv_aluop", aluop_o, 2);
        check("inv_rt_addr", rt_addr_o, 7);
        check("inv_cnt", bubble_cnt_o, 2);

        // Stalled invalid slot is not counted
        stall_i = 1;
        step();
        step();
        check("stall_inv_cnt", bubble_cnt_o, 2);

        // Saturation on the 4-bit instance
        clear_inputs();
        rst_i = 1'b0;
        step();
        check("sat_rst_cnt", s_bubble_cnt_o, 0);
        rst_i = 1'b1;
        flush_i = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("sat_cnt_%0d", i), s_bubble_cnt_o, (i + 1 > 15) ? 15 : i + 1);
        end
        check("wide_cnt_20", bubble_cnt_o, 20);
        flush_i = 0;
        rst_i = 1'b0;
        step();
        check("sat_rerst_cnt", s_bubble_cnt_o, 0);
        check("wide_rerst_cnt", bubble_cnt_o, 0);

        // Back-to-back valid loads; output must not follow inputs between edges
        rst_i = 1'b1;
        clear_inputs();
        valid_i = 1;
        for (int i = 0; i < 8; i++) imm_seq[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
        for (int i = 0; i < 8; i++) begin
            imm_i = imm_seq[i];
            if (i > 0) begin
                #1;
                check($sformatf("b2b_hold_%0d", i), imm_o, 64'(imm_seq[i-1]));
            end
            step();
            check($sformatf("b2b_imm_%0d", i), imm_o, 64'(imm_seq[i]));
        end
        check("b2b_valid", valid_o, 1);
        check("b2b_cnt", bubble_cnt_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between the decode stage and the execute stage of the 5-stage CPU.
- Captures decoded control signals, register-file read data, the 32-bit sign-extended immediate from the sign-extension unit, and the rs/rt/rd register addresses on each clock.
- Supports hazard-unit stall (hold) and branch/hazard flush (bubble insertion).
- Keeps a saturating count of bubbles injected into the execute stage for performance debug.

Parameters:
- DATA_W, 32, width of register read data and immediate.
- REG_ADDR_W, 5, width of register specifiers.
- CNT_W, 16, width of bubble counter.

Ports:
- clk_i  input  1  pipeline clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-low.
- stall_i  input  1  hazard unit hold request; register keeps current contents.
- flush_i  input  1  insert bubble; overrides stall_i.
- valid_i  input  1  decode stage holds a real instruction.
- regwrite_i  input  1  WB control.
- memtoreg_i  input  1  WB control.
- memread_i  input  1  MEM control.
- memwrite_i  input  1  MEM control.
- alusrc_i  input  1  EX control.
- regdst_i  input  1  EX control.
- aluop_i  input  2  EX control.
- rs_data_i  input  DATA_W  register-file read port 1.
- rt_data_i  input  DATA_W  register-file read port 2.
- imm_i  input  DATA_W  sign-extended immediate from the sign-extension unit.
- rs_addr_i, rt_addr_i, rd_addr_i  input  REG_ADDR_W  each; register specifiers.
- valid_o, regwrite_o, memtoreg_o, memread_o, memwrite_o, alusrc_o, regdst_o  output  1  each; registered copies.
- aluop_o  output  2  registered copy.
- rs_data_o, rt_data_o, imm_o  output  DATA_W  registered copies.
- rs_addr_o, rt_addr_o, rd_addr_o  output  REG_ADDR_W  registered copies; used by the forwarding and hazard units.
- bubble_cnt_o  output  CNT_W  number of bubbles injected since reset, saturating.

Behaviour:
- Latency: 1 cycle. Inputs sampled at a rising edge appear on the outputs immediately after that edge.
- No combinational path from any input to any output.
- Per-edge priority, highest first: reset, flush, stall, load.
- Reset (rst_i=0 at edge): every output cleared to 0, including valid_o, all control bits, data, immediate, addresses and bubble_cnt_o. Reset mid-stall or mid-flush still clears everything.
- Flush (rst_i=1, flush_i=1):
  - valid_o, all control outputs, data outputs, imm_o and address outputs go to 0.
  - bubble_cnt_o increments.
  - Applies regardless of stall_i and valid_i.
- Stall (rst_i=1, flush_i=0, stall_i=1): every output, including bubble_cnt_o, holds its previous value. Stall may persist any number of cycles.
- Load with valid_i=1 (no reset, flush or stall): all fields captured from inputs; valid_o=1.
- Load with valid_i=0:
  - valid_o, regwrite_o, memread_o, memwrite_o and memtoreg_o forced to 0, so the bubble cannot change architectural state.
  - alusrc_o, regdst_o, aluop_o, data, immediate and address fields are captured as presented.
  - bubble_cnt_o increments.
- Bubble counter:
  - Increments by exactly 1 per edge on which a bubble is latched (flush, or load with valid_i=0).
  - Saturates at 2^CNT_W-1 and never wraps.
  - Stalled cycles are not counted.
- Immediate is passed through bit-exact with no re-extension. 0xFFFF8000 in gives 0xFFFF8000 out.
- Outputs stay stable between edges irrespective of input toggling.

Test Plan:
- Reset: hold rst_i=0 for 2 edges with random inputs -> all outputs 0 and bubble_cnt_o=0. Release with valid_i=1, regwrite_i=1, imm_i=0xFFFF8000, rd_addr_i=5 -> next edge regwrite_o=1, imm_o=0xFFFF8000, rd_addr_o=5, valid_o=1.
- Stall: load rs_data_i=0x12345678, then assert stall_i for 3 edges while rs_data_i=0xDEADBEEF -> rs_data_o stays 0x12345678 for all 3 edges. Release -> 0xDEADBEEF one edge later; bubble_cnt_o unchanged.
- Flush overrides stall: stall_i=1, flush_i=1, memwrite_i=1, valid_i=1 -> next edge memwrite_o=0, valid_o=0, all data outputs 0, bubble_cnt_o incremented by 1.
- Invalid load: valid_i=0, regwrite_i=1, memwrite_i=1, aluop_i=2'b10, rt_addr_i=7 -> regwrite_o=0, memwrite_o=0, valid_o=0, aluop_o=2'b10, rt_addr_o=7, bubble_cnt_o+1.
- Saturation: CNT_W=4, apply 20 consecutive flushes -> bubble_cnt_o reaches 15 and stays 15. Apply rst_i=0 -> bubble_cnt_o returns to 0.
- Back-to-back: 8 consecutive valid loads with distinct imm_i values, no stall or flush -> imm_o reproduces the sequence delayed exactly 1 cycle, with no drops or duplicates.
